// File: rtl/dram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dram_arbiter
// Brief    : Two-port round-robin arbiter and access sequencer for the
//            single-port, read-first, 1-cycle-latency data RAM. Emulates
//            byte-enable writes on the full-word RAM with a read-modify-write.
// Revision : 1.0 - initial release
// ============================================================================
module dram_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
) (
    input  logic                  clk,
    input  logic                  aresetn,

    // Port 0 request / response
    input  logic                  i_req0_valid,
    output logic                  o_req0_ready,
    input  logic                  i_req0_wen,
    input  logic [ADDR_W-1:0]     i_req0_addr,
    input  logic [DATA_W/8-1:0]   i_req0_be,
    input  logic [DATA_W-1:0]     i_req0_data,
    output logic                  o_rsp0_valid,
    output logic [DATA_W-1:0]     o_rsp0_data,

    // Port 1 request / response
    input  logic                  i_req1_valid,
    output logic                  o_req1_ready,
    input  logic                  i_req1_wen,
    input  logic [ADDR_W-1:0]     i_req1_addr,
    input  logic [DATA_W/8-1:0]   i_req1_be,
    input  logic [DATA_W-1:0]     i_req1_data,
    output logic                  o_rsp1_valid,
    output logic [DATA_W-1:0]     o_rsp1_data,

    // RAM side
    output logic                  o_ram_en,
    output logic                  o_ram_wen,
    output logic [ADDR_W-1:0]     o_ram_addr,
    output logic [DATA_W-1:0]     o_ram_wdata,
    input  logic [DATA_W-1:0]     i_ram_rdata,

    output logic                  o_busy
);

    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        MERGE = 2'd2,
        RESP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // State and latched request
    // ------------------------------------------------------------------
    state_t              state_q, state_d;
    logic                ptr_q,   ptr_d;     // 0: port 0 preferred
    logic                owner_q, owner_d;   // port that owns the transaction
    logic                wen_q,   wen_d;
    logic [ADDR_W-1:0]   addr_q,  addr_d;
    logic [BE_W-1:0]     be_q,    be_d;
    logic [DATA_W-1:0]   data_q,  data_d;

    // Combinational helpers
    logic                w_gnt0;
    logic                w_gnt1;
    logic                w_idle;
    logic                w_be_full;
    logic                w_be_zero;
    logic [DATA_W-1:0]   w_merged;

    // Raw (ungated) outputs from the FSM
    logic                w_ram_en;
    logic                w_ram_wen;
    logic [ADDR_W-1:0]   w_ram_addr;
    logic [DATA_W-1:0]   w_ram_wdata;
    logic                w_rsp0_valid;
    logic                w_rsp1_valid;

    assign w_idle    = (state_q == IDLE);
    assign w_be_full = &be_q;
    assign w_be_zero = ~|be_q;

    // A lone requester always wins; on contention the pointer decides.
    assign w_gnt0 = i_req0_valid & (~i_req1_valid | ~ptr_q);
    assign w_gnt1 = i_req1_valid & (~i_req0_valid |  ptr_q);

    // Byte merge for partial writes: new bytes where enabled, old word elsewhere.
    genvar k;
    generate
        for (k = 0; k < BE_W; k++) begin : g_merge
            assign w_merged[8*k +: 8] = be_q[k] ? data_q[8*k +: 8]
                                                : i_ram_rdata[8*k +: 8];
        end
    endgenerate

    // State register and request latch, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            owner_q <= 1'b0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            data_q  <= data_d;
        end
    end

    // Next-state, request capture and RAM/response sequencing.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        owner_d      = owner_q;
        wen_d        = wen_q;
        addr_d       = addr_q;
        be_d         = be_q;
        data_d       = data_q;
        w_ram_en     = 1'b0;
        w_ram_wen    = 1'b0;
        w_ram_addr   = '0;
        w_ram_wdata  = '0;
        w_rsp0_valid = 1'b0;
        w_rsp1_valid = 1'b0;

        case (state_q)
            IDLE: begin
                if (w_gnt0 || w_gnt1) begin
                    state_d = ACC;
                    owner_d = w_gnt1;
                    ptr_d   = ~w_gnt1;     // hand priority to the other port
                    if (w_gnt1) begin
                        wen_d  = i_req1_wen;
                        addr_d = i_req1_addr;
                        be_d   = i_req1_be;
                        data_d = i_req1_data;
                    end else begin
                        wen_d  = i_req0_wen;
                        addr_d = i_req0_addr;
                        be_d   = i_req0_be;
                        data_d = i_req0_data;
                    end
                end
            end

            ACC: begin
                w_ram_en   = 1'b1;
                w_ram_addr = addr_q;
                // Full-word writes go straight in; everything else is a read.
                if (wen_q && w_be_full) begin
                    w_ram_wen   = 1'b1;
                    w_ram_wdata = data_q;
                end
                if (wen_q && !w_be_full && !w_be_zero) begin
                    state_d = MERGE;
                end else begin
                    state_d = RESP;
                end
            end

            MERGE: begin
                // Old word from the ACC read is on i_ram_rdata now.
                w_ram_en    = 1'b1;
                w_ram_wen   = 1'b1;
                w_ram_addr  = addr_q;
                w_ram_wdata = w_merged;
                state_d     = RESP;
            end

            RESP: begin
                w_rsp0_valid = ~owner_q;
                w_rsp1_valid =  owner_q;
                state_d      = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake and RAM strobes are forced low while reset is held.
    assign o_req0_ready = aresetn & w_idle & w_gnt0;
    assign o_req1_ready = aresetn & w_idle & w_gnt1;
    assign o_ram_en     = aresetn & w_ram_en;
    assign o_ram_wen    = aresetn & w_ram_wen;
    assign o_ram_addr   = w_ram_addr;
    assign o_ram_wdata  = w_ram_wdata;
    assign o_rsp0_valid = aresetn & w_rsp0_valid;
    assign o_rsp1_valid = aresetn & w_rsp1_valid;
    assign o_rsp0_data  = i_ram_rdata;
    assign o_rsp1_data  = i_ram_rdata;
    assign o_busy       = ~w_idle;

endmodule
`default_nettype wire

// File: tb/tb_dram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dram_arbiter
// Brief    : Directed testbench for dram_arbiter with a read-first RAM model
//            and a response scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dram_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 10;
    localparam int BE_W   = DATA_W / 8;

    logic                clk = 1'b0;
    logic                aresetn = 1'b0;
    logic                i_req0_valid = 1'b0, i_req0_wen = 1'b0;
    logic [ADDR_W-1:0]   i_req0_addr = '0;
    logic [BE_W-1:0]     i_req0_be = '0;
    logic [DATA_W-1:0]   i_req0_data = '0;
    logic                i_req1_valid = 1'b0, i_req1_wen = 1'b0;
    logic [ADDR_W-1:0]   i_req1_addr = '0;
    logic [BE_W-1:0]     i_req1_be = '0;
    logic [DATA_W-1:0]   i_req1_data = '0;
    logic                o_req0_ready, o_req1_ready;
    logic                o_rsp0_valid, o_rsp1_valid;
    logic [DATA_W-1:0]   o_rsp0_data, o_rsp1_data;
    logic                o_ram_en, o_ram_wen, o_busy;
    logic [ADDR_W-1:0]   o_ram_addr;
    logic [DATA_W-1:0]   o_ram_wdata;
    logic [DATA_W-1:0]   ram_rdata = '0;

    int checks = 0;
    int errors = 0;
    int wen_count = 0;
    logic [32:0] sb_q[$];          // {port, expected response data}

    always #5 clk = ~clk;

    dram_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .aresetn      (aresetn),
        .i_req0_valid (i_req0_valid),
        .o_req0_ready (o_req0_ready),
        .i_req0_wen   (i_req0_wen),
        .i_req0_addr  (i_req0_addr),
        .i_req0_be    (i_req0_be),
        .i_req0_data  (i_req0_data),
        .o_rsp0_valid (o_rsp0_valid),
        .o_rsp0_data  (o_rsp0_data),
        .i_req1_valid (i_req1_valid),
        .o_req1_ready (o_req1_ready),
        .i_req1_wen   (i_req1_wen),
        .i_req1_addr  (i_req1_addr),
        .i_req1_be    (i_req1_be),
        .i_req1_data  (i_req1_data),
        .o_rsp1_valid (o_rsp1_valid),
        .o_rsp1_data  (o_rsp1_data),
        .o_ram_en     (o_ram_en),
        .o_ram_wen    (o_ram_wen),
        .o_ram_addr   (o_ram_addr),
        .o_ram_wdata  (o_ram_wdata),
        .i_ram_rdata  (ram_rdata),
        .o_busy       (o_busy)
    );

    // Read-first, 1-cycle-latency RAM model.
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        if (o_ram_en) begin
            ram_rdata <= mem[o_ram_addr];
            if (o_ram_wen) mem[o_ram_addr] <= o_ram_wdata;
        end
        if (o_ram_en && o_ram_wen) wen_count <= wen_count + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Response monitor: every response must match the head of the scoreboard.
    always @(negedge clk) begin
        logic [32:0] e;
        #2;
        if (o_rsp0_valid || o_rsp1_valid) begin
            check("rsp_onehot", {63'd0, o_rsp0_valid & o_rsp1_valid}, 64'd0);
            if (sb_q.size() == 0) begin
                check("rsp_unexpected", {63'd0, o_rsp0_valid | o_rsp1_valid}, 64'd0);
            end else begin
                e = sb_q.pop_front();
                check("rsp_port", {63'd0, o_rsp1_valid}, {63'd0, e[32]});
                check("rsp_data", o_rsp1_valid ? o_rsp1_data : o_rsp0_data, e[31:0]);
            end
        end
    end

    task automatic drive(input int p, input logic v, input logic w, input logic [ADDR_W-1:0] a,
                         input logic [BE_W-1:0] be, input logic [DATA_W-1:0] d);
        if (p == 0) begin
            i_req0_valid = v; i_req0_wen = w; i_req0_addr = a; i_req0_be = be; i_req0_data = d;
        end else begin
            i_req1_valid = v; i_req1_wen = w; i_req1_addr = a; i_req1_be = be; i_req1_data = d;
        end
    endtask

    // One complete transaction on a single port with cycle-accurate checks.
    task automatic issue(input int p, input logic w, input logic [ADDR_W-1:0] a,
                         input logic [BE_W-1:0] be, input logic [DATA_W-1:0] d,
                         input logic [DATA_W-1:0] exp_rsp, input logic [DATA_W-1:0] exp_merge);
        logic full    = w && (be == 4'hF);
        logic partial = w && (be != 4'h0) && (be != 4'hF);
        logic pb      = (p != 0);
        @(negedge clk);
        drive(p, 1'b1, w, a, be, d);
        #1;
        check("ready_win",  {63'd0, pb ? o_req1_ready : o_req0_ready}, 64'd1);
        check("ready_lose", {63'd0, pb ? o_req0_ready : o_req1_ready}, 64'd0);
        check("idle_no_en", {63'd0, o_ram_en}, 64'd0);
        sb_q.push_back({pb, exp_rsp});
        @(negedge clk);                                   // T+1: ACC
        drive(p, 1'b0, 1'b0, '0, '0, '0);
        #1;
        check("acc_en",    {63'd0, o_ram_en}, 64'd1);
        check("acc_wen",   {63'd0, o_ram_wen}, {63'd0, full});
        check("acc_addr",  {54'd0, o_ram_addr}, {54'd0, a});
        check("acc_ready", {63'd0, o_req0_ready | o_req1_ready}, 64'd0);
        check("acc_busy",  {63'd0, o_busy}, 64'd1);
        if (full) check("acc_wdata", {32'd0, o_ram_wdata}, {32'd0, d});
        if (partial) begin
            @(negedge clk);                               // T+2: MERGE
            #1;
            check("merge_en",    {63'd0, o_ram_en & o_ram_wen}, 64'd1);
            check("merge_wdata", {32'd0, o_ram_wdata}, {32'd0, exp_merge});
            check("merge_rsp",   {63'd0, o_rsp0_valid | o_rsp1_valid}, 64'd0);
        end
        @(negedge clk);                                   // response cycle
        #1;
        check("resp_owner", {63'd0, pb ? o_rsp1_valid : o_rsp0_valid}, 64'd1);
        check("resp_other", {63'd0, pb ? o_rsp0_valid : o_rsp1_valid}, 64'd0);
        check("resp_no_en", {63'd0, o_ram_en}, 64'd0);
        @(negedge clk);
        #1;
        check("back_idle", {63'd0, o_busy | o_rsp0_valid | o_rsp1_valid}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wc;
        int n;
        int last;
        logic exp_g;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
        mem[10'h005] = 32'hDEADBEEF;
        mem[10'h020] = 32'hAABBCCDD;
        mem[10'h030] = 32'h55555555;
        mem[10'h040] = 32'hCAFEF00D;

        // Reset with a request pending: everything gated off.
        drive(0, 1'b1, 1'b0, 10'h005, 4'h0, 32'h0);
        @(negedge clk); @(negedge clk);
        #1;
        check("rst_ready",    {63'd0, o_req0_ready | o_req1_ready}, 64'd0);
        check("rst_ram_en",   {63'd0, o_ram_en | o_ram_wen}, 64'd0);
        check("rst_rsp",      {63'd0, o_rsp0_valid | o_rsp1_valid}, 64'd0);
        check("rst_busy",     {63'd0, o_busy}, 64'd0);
        check("rst_addr",     {54'd0, o_ram_addr}, 64'd0);
        check("rst_wdata",    {32'd0, o_ram_wdata}, 64'd0);
        check("rst_rsp_data", {32'd0, o_rsp0_data}, {32'd0, ram_rdata});
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        aresetn = 1'b1;

        // Port 0 read.
        issue(0, 1'b0, 10'h005, 4'h0, 32'h0, 32'hDEADBEEF, 32'h0);
        // Port 1 full write then read back.
        issue(1, 1'b1, 10'h010, 4'hF, 32'h12345678, 32'h00000000, 32'h0);
        issue(1, 1'b0, 10'h010, 4'h0, 32'h0, 32'h12345678, 32'h0);
        // Port 0 partial write (read-modify-write) then read back.
        issue(0, 1'b1, 10'h020, 4'b0101, 32'h11223344, 32'hAABBCCDD, 32'hAA22CC44);
        issue(0, 1'b0, 10'h020, 4'h0, 32'h0, 32'hAA22CC44, 32'h0);
        // be=0 write is a no-write.
        wc = wen_count;
        issue(1, 1'b1, 10'h030, 4'h0, 32'hFFFFFFFF, 32'h55555555, 32'h0);
        check("be0_no_wen", wen_count - wc, 64'd0);
        issue(1, 1'b0, 10'h030, 4'h0, 32'h0, 32'h55555555, 32'h0);

        // Round-robin with both ports continuously valid after reset.
        @(negedge clk);
        aresetn = 1'b0;
        @(negedge clk);
        aresetn = 1'b1;
        drive(0, 1'b1, 1'b0, 10'h005, 4'h0, 32'h0);
        drive(1, 1'b1, 1'b0, 10'h010, 4'h0, 32'h0);
        n = 0; last = 0; exp_g = 1'b0;
        for (int cyc = 0; cyc < 20 && n < 4; cyc++) begin
            #1;
            if (o_req0_ready || o_req1_ready) begin
                check("rr_port", {63'd0, o_req1_ready}, {63'd0, exp_g});
                if (n > 0) check("rr_gap", cyc - last, 64'd3);
                sb_q.push_back({o_req1_ready, o_req1_ready ? 32'h12345678 : 32'hDEADBEEF});
                exp_g = ~exp_g;
                last = cyc;
                n++;
            end
            @(negedge clk);
        end
        check("rr_grants", n, 64'd4);
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0, '0);
        repeat (4) @(negedge clk);

        // Leave the pointer favouring port 1, then abort a partial write in ACC.
        issue(0, 1'b0, 10'h005, 4'h0, 32'h0, 32'hDEADBEEF, 32'h0);
        wc = wen_count;
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 10'h040, 4'b0011, 32'h11111111);
        #1;
        check("abort_ready", {63'd0, o_req0_ready}, 64'd1);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        aresetn = 1'b0;
        #1;
        check("abort_en",  {63'd0, o_ram_en | o_ram_wen}, 64'd0);
        check("abort_rsp", {63'd0, o_rsp0_valid | o_rsp1_valid}, 64'd0);
        @(negedge clk);
        aresetn = 1'b1;
        #1;
        check("abort_idle", {63'd0, o_busy}, 64'd0);
        repeat (3) @(negedge clk);
        check("abort_no_write", wen_count - wc, 64'd0);

        // After reset the pointer favours port 0 again.
        drive(0, 1'b1, 1'b0, 10'h040, 4'h0, 32'h0);
        drive(1, 1'b1, 1'b0, 10'h005, 4'h0, 32'h0);
        #1;
        check("post_rst_ready0", {63'd0, o_req0_ready}, 64'd1);
        check("post_rst_ready1", {63'd0, o_req1_ready}, 64'd0);
        sb_q.push_back({1'b0, 32'hCAFEF00D});
        @(negedge clk);
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0, '0);
        repeat (4) @(negedge clk);

        check("sb_empty", sb_q.size(), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
